// File: rtl/tt_sweep_checker_if.sv
// rtl/tt_sweep_checker_if.sv - stimulus/response bundle between the sweep checker and its lab harness.
interface tt_sweep_checker_if #(
    parameter int N_IN = 3,
    parameter int CH   = 6
);
    logic                        start;
    logic [CH*(2**N_IN)-1:0]     expected;
    logic [CH-1:0]               y_in;
    logic [N_IN-1:0]             vec;
    logic                        busy;
    logic                        done;
    logic                        pass;
    logic [CH-1:0]               fail_mask;
    logic [15:0]                 err_count;
    logic [N_IN-1:0]             first_fail_vec;
    logic [7:0]                  first_fail_ch;

    modport master (
        output start, expected, y_in,
        input  vec, busy, done, pass, fail_mask, err_count, first_fail_vec, first_fail_ch
    );

    modport slave (
        input  start, expected, y_in,
        output vec, busy, done, pass, fail_mask, err_count, first_fail_vec, first_fail_ch
    );
endinterface

// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - truth-table sweeper comparing CH channels against expected tables.
// Optional first-mismatch capture is enabled by defining TT_SWEEP_FIRST_FAIL_EN.
module tt_sweep_checker #(
    parameter int N_IN   = 3,
    parameter int CH     = 6,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    tt_sweep_checker_if.slave bus
);
    localparam int NV = 1 << N_IN;
    localparam logic [7:0]      SETTLE_LAST = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST    = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SAMPLE,
        DONE
    } state_t;

    // With no settle time each vector is sampled in the cycle it is applied.
    localparam state_t NEXT_VEC_STATE = (SETTLE == 0) ? SAMPLE : HOLD;

    state_t          state;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic [CH-1:0]   fail_mask;
    logic [15:0]     err_count;
    logic [7:0]      settle_cnt;

    logic [CH-1:0]   mism;
    logic [15:0]     mism_cnt;
    logic [16:0]     err_sum;
    logic [15:0]     err_next;
    logic            start_ok;

    always_comb begin
        mism     = '0;
        mism_cnt = '0;
        for (int c = 0; c < CH; c++) begin
            mism[c]  = bus.y_in[c] ^ bus.expected[c*NV + int'(vec)];
            mism_cnt = mism_cnt + 16'(mism[c]);
        end
    end

    assign err_sum  = {1'b0, err_count} + {1'b0, mism_cnt};
    assign err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    assign start_ok = bus.start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail_mask  <= '0;
            err_count  <= '0;
            settle_cnt <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        fail_mask  <= '0;
                        err_count  <= '0;
                        vec        <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        settle_cnt <= '0;
                        state      <= NEXT_VEC_STATE;
                    end
                end
                HOLD: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    fail_mask <= fail_mask | mism;
                    err_count <= err_next;
                    if (vec == VEC_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        vec        <= vec + N_IN'(1);
                        settle_cnt <= '0;
                        state      <= NEXT_VEC_STATE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TT_SWEEP_FIRST_FAIL_EN
    logic            ff_seen;
    logic [N_IN-1:0] ff_vec;
    logic [7:0]      ff_ch;
    logic [7:0]      low_idx;

    always_comb begin
        low_idx = '0;
        for (int c = CH - 1; c >= 0; c--) begin
            if (mism[c]) low_idx = 8'(c);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff_seen <= 1'b0;
            ff_vec  <= '0;
            ff_ch   <= '0;
        end else if (start_ok) begin
            ff_seen <= 1'b0;
            ff_vec  <= '0;
            ff_ch   <= '0;
        end else if ((state == SAMPLE) && !ff_seen && (|mism)) begin
            ff_seen <= 1'b1;
            ff_vec  <= vec;
            ff_ch   <= low_idx;
        end
    end

    assign bus.first_fail_vec = ff_vec;
    assign bus.first_fail_ch  = ff_ch;
`else
    logic unused_start_ok;
    assign unused_start_ok    = start_ok;
    assign bus.first_fail_vec = '0;
    assign bus.first_fail_ch  = '0;
`endif

    assign bus.vec       = vec;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = done && (err_count == 16'd0);
    assign bus.fail_mask = fail_mask;
    assign bus.err_count = err_count;
endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb/tb_tt_sweep_checker.sv - randomized self-checking bench for tt_sweep_checker.
module tb_tt_sweep_checker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tt_sweep_checker_if #(.N_IN(3), .CH(6)) bus_a ();
    tt_sweep_checker_if #(.N_IN(4), .CH(1)) bus_b ();

    tt_sweep_checker #(.N_IN(3), .CH(6), .SETTLE(1)) dut_a (.clk(clk), .reset(rst), .bus(bus_a));
    tt_sweep_checker #(.N_IN(4), .CH(1), .SETTLE(0)) dut_b (.clk(clk), .reset(rst), .bus(bus_b));

    // Behavioural DUT for channel bank A: correct output XOR an injected fault table.
    logic [47:0] flp_a;
    always_comb begin
        bus_a.y_in = '0;
        for (int c = 0; c < 6; c++)
            bus_a.y_in[c] = bus_a.expected[c*8 + int'(bus_a.vec)] ^ flp_a[c*8 + int'(bus_a.vec)];
    end
    assign bus_b.y_in = 1'b1;

    int n_pass  = 0;
    int n_total = 0;

    int          m_err;
    logic [5:0]  m_mask;
    logic [2:0]  m_ffv;
    logic [7:0]  m_ffc;
    int          done_at;
    int          seq_err;

    task automatic model_a(input logic [47:0] e, input logic [47:0] f);
        bit seen = 0;
        logic y;
        m_err = 0; m_mask = '0; m_ffv = '0; m_ffc = '0;
        for (int v = 0; v < 8; v++)
            for (int c = 0; c < 6; c++) begin
                y = e[c*8+v] ^ f[c*8+v];
                if (y != e[c*8+v]) begin
                    m_err++;
                    m_mask[c] = 1'b1;
                    if (!seen) begin seen = 1; m_ffv = 3'(v); m_ffc = 8'(c); end
                end
            end
`ifndef TT_SWEEP_FIRST_FAIL_EN
        m_ffv = '0; m_ffc = '0;
`endif
    endtask

    // Start a sweep on bank A and record timing; poke adds a start pulse at edge t0+5.
    task automatic run_sweep_a(input logic [47:0] e, input logic [47:0] f, input bit poke);
        bus_a.expected = e;
        flp_a = f;
        @(negedge clk) bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
        done_at = -1;
        seq_err = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) begin done_at = k; break; end
            if (!(bus_a.busy === 1'b1 && bus_a.vec === 3'(k / 2))) seq_err++;
            if (poke) bus_a.start = (k == 4);
        end
        bus_a.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.expected = '0; flp_a = '0;
        bus_b.start = 1'b0; bus_b.expected = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus_a.vec, bus_a.busy, bus_a.done, bus_a.pass, bus_a.fail_mask, bus_a.err_count,
             bus_a.first_fail_vec, bus_a.first_fail_ch} !== '0)
            $display("FAIL reset_a outputs got vec=%0d busy=%b done=%b err=%0d mask=%b exp all 0",
                     bus_a.vec, bus_a.busy, bus_a.done, bus_a.err_count, bus_a.fail_mask);
        else n_pass++;
        n_total++;
        if ({bus_b.vec, bus_b.busy, bus_b.done, bus_b.pass, bus_b.fail_mask, bus_b.err_count} !== '0)
            $display("FAIL reset_b outputs got vec=%0d busy=%b done=%b err=%0d exp all 0",
                     bus_b.vec, bus_b.busy, bus_b.done, bus_b.err_count);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_golden();
        logic [63:0] r = {$urandom(), $urandom()};
        run_sweep_a(r[47:0], '0, 1'b0);
        model_a(r[47:0], '0);
        n_total++; if (done_at !== 16) $display("FAIL golden done_at got %0d exp 16", done_at); else n_pass++;
        n_total++; if (seq_err !== 0) $display("FAIL golden vec_seq got %0d bad cycles exp 0", seq_err); else n_pass++;
        n_total++; if (bus_a.pass !== 1'b1) $display("FAIL golden pass got %b exp 1", bus_a.pass); else n_pass++;
        n_total++; if (bus_a.err_count !== 16'(m_err)) $display("FAIL golden err_count got %0d exp %0d", bus_a.err_count, m_err); else n_pass++;
        n_total++; if (bus_a.fail_mask !== m_mask) $display("FAIL golden fail_mask got %b exp %b", bus_a.fail_mask, m_mask); else n_pass++;
        n_total++; if (bus_a.vec !== 3'd7) $display("FAIL golden vec_hold got %0d exp 7", bus_a.vec); else n_pass++;
    endtask

    task automatic test_single_fault();
        logic [63:0] r = {$urandom(), $urandom()};
        logic [47:0] f = '0;
        f[3*8+5] = 1'b1;
        run_sweep_a(r[47:0], f, 1'b0);
        model_a(r[47:0], f);
        n_total++; if (bus_a.err_count !== 16'd1) $display("FAIL single err_count got %0d exp 1", bus_a.err_count); else n_pass++;
        n_total++; if (bus_a.fail_mask !== 6'b001000) $display("FAIL single fail_mask got %b exp 001000", bus_a.fail_mask); else n_pass++;
        n_total++; if (bus_a.pass !== 1'b0) $display("FAIL single pass got %b exp 0", bus_a.pass); else n_pass++;
        n_total++;
        if (bus_a.first_fail_vec !== m_ffv || bus_a.first_fail_ch !== m_ffc)
            $display("FAIL single first_fail got v=%0d c=%0d exp v=%0d c=%0d",
                     bus_a.first_fail_vec, bus_a.first_fail_ch, m_ffv, m_ffc);
        else n_pass++;
    endtask

    task automatic test_multi_fault();
        logic [63:0] r = {$urandom(), $urandom()};
        logic [47:0] f = '0;
        f[7:0] = 8'hFF;
        f[1*8+2] = 1'b1;
        f[4*8+2] = 1'b1;
        run_sweep_a(r[47:0], f, 1'b0);
        model_a(r[47:0], f);
        n_total++; if (bus_a.err_count !== 16'd10) $display("FAIL multi err_count got %0d exp 10", bus_a.err_count); else n_pass++;
        n_total++; if (bus_a.fail_mask !== 6'b010011) $display("FAIL multi fail_mask got %b exp 010011", bus_a.fail_mask); else n_pass++;
        n_total++;
        if (bus_a.first_fail_vec !== m_ffv || bus_a.first_fail_ch !== m_ffc)
            $display("FAIL multi first_fail got v=%0d c=%0d exp v=%0d c=%0d",
                     bus_a.first_fail_vec, bus_a.first_fail_ch, m_ffv, m_ffc);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [63:0] r = {$urandom(), $urandom()};
            logic [63:0] a = {$urandom(), $urandom()};
            logic [63:0] b = {$urandom(), $urandom()};
            logic [63:0] d = {$urandom(), $urandom()};
            logic [47:0] f = a[47:0] & b[47:0] & d[47:0];
            run_sweep_a(r[47:0], f, 1'b0);
            model_a(r[47:0], f);
            n_total++;
            if (done_at !== 16 || seq_err !== 0)
                $display("FAIL random[%0d] timing got done_at=%0d seq_err=%0d exp 16/0", i, done_at, seq_err);
            else n_pass++;
            n_total++;
            if (bus_a.err_count !== 16'(m_err) || bus_a.fail_mask !== m_mask || bus_a.pass !== (m_err == 0))
                $display("FAIL random[%0d] result got err=%0d mask=%b pass=%b exp err=%0d mask=%b",
                         i, bus_a.err_count, bus_a.fail_mask, bus_a.pass, m_err, m_mask);
            else n_pass++;
            n_total++;
            if (bus_a.first_fail_vec !== m_ffv || bus_a.first_fail_ch !== m_ffc)
                $display("FAIL random[%0d] first_fail got v=%0d c=%0d exp v=%0d c=%0d",
                         i, bus_a.first_fail_vec, bus_a.first_fail_ch, m_ffv, m_ffc);
            else n_pass++;
        end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] r = {$urandom(), $urandom()};
        run_sweep_a(r[47:0], '0, 1'b1);
        n_total++;
        if (done_at !== 16 || seq_err !== 0)
            $display("FAIL busy_start timing got done_at=%0d seq_err=%0d exp 16/0", done_at, seq_err);
        else n_pass++;
    endtask

    task automatic test_start_in_done();
        logic [63:0] r = {$urandom(), $urandom()};
        logic [47:0] f = '0;
        f[2*8+6] = 1'b1;
        run_sweep_a(r[47:0], f, 1'b0);
        bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b1 || bus_a.err_count !== 16'd0 ||
            bus_a.fail_mask !== 6'd0 || bus_a.vec !== 3'd0)
            $display("FAIL done_restart got done=%b busy=%b err=%0d mask=%b vec=%0d exp 0/1/0/0/0",
                     bus_a.done, bus_a.busy, bus_a.err_count, bus_a.fail_mask, bus_a.vec);
        else n_pass++;
        for (int k = 0; k < 40 && bus_a.done !== 1'b1; k++) @(negedge clk);
        n_total++;
        if (bus_a.done !== 1'b1 || bus_a.err_count !== 16'd1)
            $display("FAIL done_restart finish got done=%b err=%0d exp 1/1", bus_a.done, bus_a.err_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_sweep();
        logic [63:0] r = {$urandom(), $urandom()};
        logic [47:0] f = '0;
        f[7:0] = 8'hFF;
        bus_a.expected = r[47:0];
        flp_a = f;
        @(negedge clk) bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
        for (int k = 0; k <= 6; k++) @(negedge clk);
        n_total++; if (bus_a.vec !== 3'd3) $display("FAIL midreset vec_before got %0d exp 3", bus_a.vec); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({bus_a.vec, bus_a.busy, bus_a.done, bus_a.pass, bus_a.fail_mask, bus_a.err_count,
             bus_a.first_fail_vec, bus_a.first_fail_ch} !== '0)
            $display("FAIL midreset outputs got vec=%0d busy=%b err=%0d mask=%b exp all 0",
                     bus_a.vec, bus_a.busy, bus_a.err_count, bus_a.fail_mask);
        else n_pass++;
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) $display("FAIL midreset no_resume got busy=%b done=%b exp 0/0", bus_a.busy, bus_a.done); else n_pass++;
        run_sweep_a(r[47:0], '0, 1'b0);
        n_total++;
        if (done_at !== 16 || bus_a.pass !== 1'b1)
            $display("FAIL midreset rerun got done_at=%0d pass=%b exp 16/1", done_at, bus_a.pass);
        else n_pass++;
    endtask

    task automatic test_settle0();
        int d_at = -1;
        int s_err = 0;
        bus_b.expected = '0;
        @(negedge clk) bus_b.start = 1'b1;
        @(posedge clk);
        #1 bus_b.start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus_b.done === 1'b1) begin d_at = k; break; end
            if (!(bus_b.busy === 1'b1 && bus_b.vec === 4'(k))) s_err++;
        end
        n_total++; if (d_at !== 16 || s_err !== 0) $display("FAIL settle0 timing got done_at=%0d seq_err=%0d exp 16/0", d_at, s_err); else n_pass++;
        n_total++; if (bus_b.err_count !== 16'd16) $display("FAIL settle0 err_count got %0d exp 16", bus_b.err_count); else n_pass++;
        n_total++; if (bus_b.fail_mask !== 1'b1 || bus_b.pass !== 1'b0) $display("FAIL settle0 mask_pass got %b/%b exp 1/0", bus_b.fail_mask, bus_b.pass); else n_pass++;
        n_total++;
        if (bus_b.first_fail_vec !== 4'd0 || bus_b.first_fail_ch !== 8'd0)
            $display("FAIL settle0 first_fail got v=%0d c=%0d exp 0/0", bus_b.first_fail_vec, bus_b.first_fail_ch);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_golden();
        test_single_fault();
        test_multi_fault();
        test_random();
        test_start_while_busy();
        test_start_in_done();
        test_reset_mid_sweep();
        test_settle0();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
